// File: rtl/stepper_move_ctrl.sv
// 4-phase full-step stepper move sequencer: accepts a move command, paces
// phase advances with a period counter and drives gated coil pattern and chip-select.
module stepper_move_ctrl #(
    parameter int CNT_W      = 16,
    parameter int DIV_W      = 16,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             hold_en,
    output logic [3:0]       phase_out,
    output logic             cs_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] eff_period;
    logic [CNT_W-1:0] steps_q;
    logic             dir_q;
    logic             done_q, aborted_q;
    logic             accept, tick;
    logic             step_en, done_d, aborted_d;
    logic [3:0]       pattern;

    assign eff_period = (cmd_period < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : cmd_period;
    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign tick       = (cnt_q == period_q - DIV_W'(1));

    always_comb begin
        state_d   = state_q;
        step_en   = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                // abort is deliberately ignored here, even alongside a new command
                if (accept) begin
                    if (cmd_steps != '0) state_d = RUN;
                    else                 done_d  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (tick) begin
                    step_en = 1'b1;
                    if (steps_q == CNT_W'(1)) state_d = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            period_q  <= '0;
            steps_q   <= '0;
            dir_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            if (accept) begin
                dir_q    <= cmd_dir;
                period_q <= eff_period;
                steps_q  <= cmd_steps;
                cnt_q    <= '0;
            end else if (busy && !abort) begin
                cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
                if (step_en) begin
                    idx_q   <= dir_q ? idx_q + 2'd1 : idx_q - 2'd1;
                    steps_q <= steps_q - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    pattern = 4'b0011;
            2'd1:    pattern = 4'b0110;
            2'd2:    pattern = 4'b1100;
            default: pattern = 4'b1001;
        endcase
    end

    assign cs_out     = busy | hold_en;
    assign phase_out  = cs_out ? pattern : 4'b0000;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign steps_left = steps_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl: per-cycle checks of phase, handshake and status
// against hand-computed timelines for each move scenario.
module tb_stepper_move_ctrl;

    logic        clk, reset;
    logic        cmd_valid, cmd_ready, cmd_dir, abort, hold_en;
    logic [15:0] cmd_steps, cmd_period, steps_left;
    logic [3:0]  phase_out;
    logic        cs_out, busy, done, aborted;
    logic [24:0] obs;

    int vectors = 0;
    int miscompares = 0;

    stepper_move_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period),
        .abort(abort), .hold_en(hold_en), .phase_out(phase_out), .cs_out(cs_out),
        .busy(busy), .done(done), .aborted(aborted), .steps_left(steps_left)
    );

    // {phase, cs, busy, ready, done, aborted, steps_left}
    assign obs = {phase_out, cs_out, busy, cmd_ready, done, aborted, steps_left};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command for one cycle T, then scramble the inputs; returns just after the accept edge.
    task automatic issue(input logic [15:0] s, input logic d, input logic [15:0] p, input logic ab);
        @(posedge clk); #1;
        cmd_steps = s; cmd_dir = d; cmd_period = p; cmd_valid = 1'b1; abort = ab;
        @(posedge clk); #1;
        cmd_valid = 1'b0; abort = 1'b0;
        cmd_steps = 16'hFFFF; cmd_period = 16'd1; cmd_dir = ~d;
    endtask

    task automatic test_reset();
        logic [24:0] exp;
        exp = {4'b0011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_held got %h want %h", obs, exp);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_release got %h want %h", obs, exp);
        end
    endtask

    task automatic test_fwd3();
        logic [3:0] ph; logic [15:0] sl; logic b, dn; logic [24:0] exp;
        hold_en = 1'b1;
        issue(16'd3, 1'b1, 16'd5, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            ph = k < 6 ? 4'b0011 : k < 11 ? 4'b0110 : k < 16 ? 4'b1100 : 4'b1001;
            sl = k < 6 ? 16'd3 : k < 11 ? 16'd2 : k < 16 ? 16'd1 : 16'd0;
            b  = (k <= 20);
            dn = (k == 21);
            exp = {ph, 1'b1, b, ~b, dn, 1'b0, sl};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL fwd3 k=%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_rev_clamp();
        logic [3:0] ph; logic [15:0] sl; logic b, dn; logic [24:0] exp;
        issue(16'd2, 1'b0, 16'd2, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            ph = k < 5 ? 4'b1001 : k < 9 ? 4'b1100 : 4'b0110;
            sl = k < 5 ? 16'd2 : k < 9 ? 16'd1 : 16'd0;
            b  = (k <= 12);
            dn = (k == 13);
            exp = {ph, 1'b1, b, ~b, dn, 1'b0, sl};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rev_clamp k=%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_zero_steps();
        logic [24:0] exp;
        issue(16'd0, 1'b1, 16'd5, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            exp = {4'b0110, 1'b1, 1'b0, 1'b1, (k == 1), 1'b0, 16'd0};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL zero_steps k=%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] ph; logic [15:0] sl; logic b, dn, ab; logic [24:0] exp;
        issue(16'd10, 1'b1, 16'd8, 1'b0);
        for (int k = 1; k <= 43; k++) begin
            @(negedge clk);
            dn = 1'b0; ab = 1'b0; b = 1'b1;
            if (k <= 32) begin
                ph = k < 9 ? 4'b0110 : k < 17 ? 4'b1100 : k < 25 ? 4'b1001 : 4'b0011;
                sl = k < 9 ? 16'd10 : k < 17 ? 16'd9 : k < 25 ? 16'd8 : 16'd7;
            end else if (k == 33) begin
                ph = 4'b0011; sl = 16'd7; b = 1'b0; ab = 1'b1;
            end else if (k < 38) begin
                ph = 4'b0011; sl = 16'd1;
            end else begin
                ph = 4'b1001; sl = 16'd0; b = (k <= 41); dn = (k == 42);
            end
            exp = {ph, 1'b1, b, ~b, dn, ab, sl};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL abort k=%0d got %h want %h", k, obs, exp);
            end
            if (k == 32) abort = 1'b1;
            if (k == 33) begin
                abort = 1'b0;
                cmd_steps = 16'd1; cmd_dir = 1'b0; cmd_period = 16'd4; cmd_valid = 1'b1;
            end
            if (k == 34) cmd_valid = 1'b0;
        end
    endtask

    task automatic test_idle_abort();
        logic [24:0] exp; logic b;
        issue(16'd1, 1'b1, 16'd4, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            b = (k <= 8);
            exp = {(k < 5 ? 4'b1001 : 4'b0011), 1'b1, b, ~b, (k == 9), 1'b0,
                   (k < 5 ? 16'd1 : 16'd0)};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL idle_abort k=%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_dwell();
        logic [3:0] ph; logic [15:0] sl; logic b; logic [24:0] exp;
        hold_en = 1'b0;
        issue(16'd1, 1'b1, 16'd4, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp = {(k < 5 ? 4'b0011 : 4'b0110), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   (k < 5 ? 16'd1 : 16'd0)};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pre_reset k=%0d got %h want %h", k, obs, exp);
            end
        end
        reset = 1'b1;
        #1;
        exp = {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL async_reset got %h want %h", obs, exp);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL post_reset k=%0d got %h want %h", k, obs, exp);
            end
        end
        issue(16'd2, 1'b1, 16'd4, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            b  = (k <= 12);
            ph = k < 5 ? 4'b0011 : k < 9 ? 4'b0110 : 4'b1100;
            sl = k < 5 ? 16'd2 : k < 9 ? 16'd1 : 16'd0;
            exp = {(b ? ph : 4'b0000), b, b, ~b, (k == 13), 1'b0, sl};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL after_reset k=%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b0; hold_en = 1'b1; abort = 1'b0; cmd_valid = 1'b0;
        cmd_steps = 16'd0; cmd_dir = 1'b0; cmd_period = 16'd0;
        #1 reset = 1'b1;
        #1;
        test_reset();
        test_fwd3();
        test_rev_clamp();
        test_zero_steps();
        test_abort();
        test_idle_abort();
        test_reset_dwell();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
